// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read path among NUM_M requesters.
// One transaction outstanding at a time; R is routed combinationally to the granted requester.
module axi_lite_rd_arbiter #(
    parameter int unsigned NUM_M  = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IdW   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_M-1:0]          s_arvalid,
    output logic [NUM_M-1:0]          s_arready,
    input  logic [NUM_M*ADDR_W-1:0]   s_araddr,
    input  logic [NUM_M*3-1:0]        s_arprot,
    output logic [NUM_M-1:0]          s_rvalid,
    input  logic [NUM_M-1:0]          s_rready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      m_arvalid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready,
    output logic [IdW-1:0]            grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   last_grant_q;
    logic             win_found;
    logic [IdW-1:0]   win_idx;
    logic [IdW-1:0]   cand;

    // Search starts one past the last served requester, wrapping modulo NUM_M.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_M; off++) begin
            cand = IdW'((32'(last_grant_q) + off) % NUM_M);
            if (!win_found && s_arvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StAddr;
            StAddr:  if (m_arvalid && m_arready) state_d = StData;
            StData:  if (m_rvalid && s_rready[grant_id]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_arvalid    <= 1'b0;
            m_araddr     <= '0;
            m_arprot     <= '0;
            grant_id     <= '0;
            last_grant_q <= IdW'(NUM_M - 1);
        end else begin
            if (state_q == StIdle && win_found) begin
                m_arvalid <= 1'b1;
                m_araddr  <= s_araddr[32'(win_idx) * ADDR_W +: ADDR_W];
                m_arprot  <= s_arprot[32'(win_idx) * 3 +: 3];
                grant_id  <= win_idx;
            end
            if (state_q == StAddr && m_arvalid && m_arready) begin
                m_arvalid <= 1'b0;
            end
            if (state_q == StData && m_rvalid && s_rready[grant_id]) begin
                last_grant_q <= grant_id;
            end
        end
    end

    // Handshake outputs are gated by reset so nothing is offered while ARESETn is low.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        busy      = (state_q != StIdle);
        if (ARESETn) begin
            unique case (state_q)
                StIdle: if (win_found) s_arready[win_idx] = 1'b1;
                StData: begin
                    s_rvalid[grant_id] = m_rvalid;
                    m_rready           = s_rready[grant_id];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Randomized self-checking bench for axi_lite_rd_arbiter against a transaction-level
// round-robin model.
module tb_axi_lite_rd_arbiter;

    localparam int NUM_M  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int IdW    = 2;

    logic                    ACLK = 1'b0;
    logic                    ARESETn;
    logic [NUM_M-1:0]        s_arvalid;
    logic [NUM_M-1:0]        s_arready;
    logic [NUM_M*ADDR_W-1:0] s_araddr;
    logic [NUM_M*3-1:0]      s_arprot;
    logic [NUM_M-1:0]        s_rvalid;
    logic [NUM_M-1:0]        s_rready;
    logic [DATA_W-1:0]       s_rdata;
    logic [1:0]              s_rresp;
    logic                    m_arvalid;
    logic [ADDR_W-1:0]       m_araddr;
    logic [2:0]              m_arprot;
    logic                    m_arready;
    logic                    m_rvalid;
    logic [DATA_W-1:0]       m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rready;
    logic [IdW-1:0]          grant_id;
    logic                    busy;

    int n_cmp = 0;
    int n_err = 0;
    int model_last;
    logic [ADDR_W-1:0] addr_tab [NUM_M];
    logic [2:0]        prot_tab [NUM_M];

    axi_lite_rd_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Round-robin rule: first valid requester after the last served one.
    function automatic int rr_pick(input int last, input logic [NUM_M-1:0] mask);
        for (int off = 1; off <= NUM_M; off++) begin
            if (mask[(last + off) % NUM_M]) return (last + off) % NUM_M;
        end
        return -1;
    endfunction

    task automatic drive_tabs();
        for (int i = 0; i < NUM_M; i++) begin
            s_araddr[i*ADDR_W +: ADDR_W] = addr_tab[i];
            s_arprot[i*3 +: 3]           = prot_tab[i];
        end
    endtask

    task automatic randomize_tabs();
        for (int i = 0; i < NUM_M; i++) begin
            addr_tab[i] = ADDR_W'($urandom);
            prot_tab[i] = 3'($urandom);
        end
    endtask

    // One full read: accept, ar_wait stalls, r_delay idle beats, rr_wait backpressure.
    task automatic do_txn(input logic [NUM_M-1:0] mask, input logic [NUM_M-1:0] noise,
                          input int ar_wait, input int r_delay, input int rr_wait,
                          input logic [1:0] resp, input logic [DATA_W-1:0] data,
                          input bit abort);
        int w;
        logic [NUM_M-1:0] oh;
        w  = rr_pick(model_last, mask);
        oh = '0;
        oh[w] = 1'b1;
        drive_tabs();
        s_arvalid = mask;
        #1;
        check_eq("idle_arready", s_arready, oh);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_rvalid", s_rvalid, '0);
        tick();
        s_arvalid = noise;
        check_eq("ar_valid", m_arvalid, 1'b1);
        check_eq("ar_addr", m_araddr, addr_tab[w]);
        check_eq("ar_prot", m_arprot, prot_tab[w]);
        check_eq("grant_id", grant_id, w);
        check_eq("busy_addr", busy, 1'b1);
        for (int i = 0; i < ar_wait; i++) begin
            m_arready = 1'b0;
            #1;
            check_eq("ar_hold_valid", m_arvalid, 1'b1);
            check_eq("ar_hold_addr", m_araddr, addr_tab[w]);
            check_eq("addr_arready", s_arready, '0);
            check_eq("addr_rvalid", s_rvalid, '0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        check_eq("ar_hs_valid", m_arvalid, 1'b1);
        tick();
        m_arready = 1'b0;
        check_eq("ar_drop", m_arvalid, 1'b0);
        if (abort) begin
            m_rvalid  = 1'b1;
            m_rdata   = data;
            m_rresp   = resp;
            s_rready  = '0;
            s_arvalid = '1;
            #1;
            check_eq("pre_rst_rvalid", s_rvalid, oh);
            ARESETn = 1'b0;
            #1;
            check_eq("rst_arvalid", m_arvalid, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_rvalid", s_rvalid, '0);
            check_eq("rst_arready", s_arready, '0);
            check_eq("rst_grant", grant_id, '0);
            tick();
            ARESETn    = 1'b1;
            m_rvalid   = 1'b0;
            s_arvalid  = '0;
            model_last = NUM_M - 1;
            return;
        end
        for (int i = 0; i < r_delay; i++) begin
            m_rvalid = 1'b0;
            s_rready = NUM_M'($urandom);
            #1;
            check_eq("data_wait_rvalid", s_rvalid, '0);
            check_eq("data_wait_rready", m_rready, s_rready[w]);
            check_eq("data_arready", s_arready, '0);
            tick();
        end
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        for (int i = 0; i < rr_wait; i++) begin
            s_rready = NUM_M'($urandom) & ~oh;
            #1;
            check_eq("bp_rvalid", s_rvalid, oh);
            check_eq("bp_rready", m_rready, 1'b0);
            check_eq("bp_busy", busy, 1'b1);
            check_eq("bp_arready", s_arready, '0);
            tick();
        end
        s_rready = oh;
        #1;
        check_eq("r_rvalid", s_rvalid, oh);
        check_eq("r_rdata", s_rdata, data);
        check_eq("r_rresp", s_rresp, resp);
        check_eq("r_rready", m_rready, 1'b1);
        tick();
        model_last = w;
        m_rvalid   = 1'b0;
        s_rready   = '0;
        s_arvalid  = '0;
        #1;
        check_eq("done_busy", busy, 1'b0);
        check_eq("done_rvalid", s_rvalid, '0);
    endtask

    initial begin
        ARESETn   = 1'b0;
        s_arvalid = '1;
        s_araddr  = '1;
        s_arprot  = '1;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        model_last = NUM_M - 1;
        #2;
        check_eq("reset_arready", s_arready, '0);
        check_eq("reset_rvalid", s_rvalid, '0);
        check_eq("reset_rready", m_rready, 1'b0);
        check_eq("reset_arvalid", m_arvalid, 1'b0);
        check_eq("reset_araddr", m_araddr, '0);
        check_eq("reset_arprot", m_arprot, '0);
        check_eq("reset_grant", grant_id, '0);
        check_eq("reset_busy", busy, 1'b0);
        tick();
        tick();
        ARESETn   = 1'b1;
        s_arvalid = '0;
        s_rready  = '0;
        m_rvalid  = 1'b0;
        tick();

        // Single request from requester 2.
        randomize_tabs();
        addr_tab[2] = 12'h7A4;
        prot_tab[2] = 3'b011;
        do_txn(4'b0100, 4'b0000, 0, 0, 0, 2'b00, 32'hDEADBEEF, 1'b0);

        // Continuous all-valid, zero-wait: rotation from the last grant.
        for (int i = 0; i < 8; i++) begin
            randomize_tabs();
            do_txn(4'hF, 4'hF, 0, 0, 0, 2'b00, $urandom, 1'b0);
        end

        // Backpressure on AR then on R for requester 1.
        randomize_tabs();
        do_txn(4'b0010, 4'b1101, 5, 0, 4, 2'b00, $urandom, 1'b0);

        // DECERR passthrough.
        randomize_tabs();
        do_txn(4'b1000, 4'b0000, 1, 1, 0, 2'b11, $urandom, 1'b0);

        // Withdrawn request from requester 1 while 0 is served.
        randomize_tabs();
        do_txn(4'b0001, 4'b0010, 2, 1, 1, 2'b00, $urandom, 1'b0);
        #1;
        check_eq("withdraw_arready", s_arready, '0);
        tick();
        check_eq("withdraw_arvalid", m_arvalid, 1'b0);
        check_eq("withdraw_busy", busy, 1'b0);

        // Reset during DATA, then 0 wins a tie against 3.
        randomize_tabs();
        do_txn(4'b0100, 4'b0000, 0, 0, 0, 2'b00, $urandom, 1'b1);
        randomize_tabs();
        do_txn(4'b1001, 4'b0000, 0, 0, 0, 2'b01, $urandom, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            randomize_tabs();
            do_txn(NUM_M'($urandom_range(1, 15)), NUM_M'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 3), 2'($urandom), $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_rd_arbiter.md
# axi_lite_rd_arbiter

Round-robin arbiter that shares one AXI4-Lite read path among NUM_M read requesters, such as bench masters or frontend DMA/config readers. It sits between the requesters and the AXI4-Lite slave fabric, where address bits [11:10] select the slave. It serialises read transactions with one outstanding at a time, forwards AR to the downstream port, and routes the R response back to the granted requester only. Write channels are not handled here.

## Interface
Parameters:
- NUM_M, 4, number of requesters (2..8)
- ADDR_W, 12, address width
- DATA_W, 32, data width

Ports:
- ACLK  in  1  clock; all state on the rising edge
- ARESETn  in  1  reset; asynchronous assertion, active-low
- s_arvalid  in  NUM_M  per-requester AR valid
- s_arready  out  NUM_M  per-requester AR ready
- s_araddr  in  NUM_M*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W]
- s_arprot  in  NUM_M*3  per-requester protection; requester i occupies bits [i*3 +: 3]
- s_rvalid  out  NUM_M  per-requester R valid
- s_rready  in  NUM_M  per-requester R ready
- s_rdata  out  DATA_W  shared read data, qualified by s_rvalid
- s_rresp  out  2  shared response, qualified by s_rvalid
- m_arvalid, m_araddr[ADDR_W], m_arprot[3]  out  downstream AR channel
- m_arready  in  1  downstream AR ready
- m_rvalid, m_rdata[DATA_W], m_rresp[2]  in  downstream R channel
- m_rready  out  1  downstream R ready
- grant_id  out  $clog2(NUM_M)  index of the current or last granted requester
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - Winner is the first requester with s_arvalid=1, searching from last_grant+1 modulo NUM_M.
  - s_arready[winner]=1 combinationally in the same cycle; every other s_arready bit is 0.
  - On that edge: latch the winner's address and prot into m_araddr/m_arprot, set m_arvalid<=1, grant_id<=winner, go to ADDR.
- **ADDR**
  - Hold m_arvalid, m_araddr and m_arprot stable.
  - On m_arvalid && m_arready: m_arvalid<=0, go to DATA.
- **DATA**
  - s_rvalid[grant_id]=m_rvalid. All other s_rvalid bits are 0.
  - m_rready=s_rready[grant_id].
  - s_rdata=m_rdata and s_rresp=m_rresp, both unmodified. This includes SLVERR and DECERR passthrough.
  - On m_rvalid && m_rready: last_grant<=grant_id, go to IDLE.
- In IDLE and ADDR: all s_rvalid bits are 0, m_rready=0, and s_rdata/s_rresp are don't-care.
- The arbiter accepts a request only with s_arready high. A requester dropping s_arvalid before it is granted is never served.
- **Reset values** (async, while ARESETn=0):
  - state=IDLE, m_arvalid=0, m_araddr=0, m_arprot=0, grant_id=0, busy=0.
  - last_grant=NUM_M-1, so requester 0 has first priority after reset.
  - Combinational outputs s_arready, s_rvalid and m_rready are 0.
- **Reset mid-transaction:** abandon the transaction immediately. No response is returned to the requester.

## Timing
- AR accept latency: a request present in IDLE is accepted in that cycle. m_arvalid rises on the following edge.
- Minimum transaction: accept in IDLE (1 cycle), then ADDR (≥1), then DATA (≥1). With zero-wait slaves this gives 3 cycles per read.
- A new grant is possible in the cycle after the R handshake.
- R routing from m_r* to s_r* is combinational with no pipeline stage. rdata is never buffered.
- Fairness: with all NUM_M requesters continuously valid, grants rotate 0,1,...,NUM_M-1,0. No requester waits more than NUM_M-1 transactions.
- m_arvalid never deasserts before m_arready; m_araddr is stable while m_arvalid=1.

## Test plan
- **Single request:** reset, then s_arvalid[2]=1 with addr 0x7A4 and prot 3'b011.
  - Expect s_arready[2] high for 1 cycle.
  - Next cycle: m_araddr=0x7A4, m_arprot=3'b011.
  - Slave returns rdata 0xDEADBEEF with OKAY: s_rvalid[2] pulses with that data, and no other s_rvalid bit asserts.
- **Round-robin:** all 4 requesters continuously valid for 8 zero-wait transactions.
  - grant_id sequence is 0,1,2,3,0,1,2,3.
  - Each transaction takes 3 cycles.
- **Backpressure:** m_arready held low for 5 cycles, then s_rready[1] held low for 4 cycles after m_rvalid rises.
  - m_araddr stays constant throughout.
  - m_rready tracks s_rready[1].
  - State stays DATA until the handshake, with no new s_arready in the meantime.
- **Error passthrough:** slave returns rresp=2'b11 (DECERR).
  - Granted requester sees s_rresp=2'b11.
  - Arbiter returns to IDLE normally.
- **Reset in DATA:** pull ARESETn low while in DATA.
  - m_arvalid=0, busy=0 and all s_rvalid bits 0 immediately (asynchronous).
  - After release, requester 0 wins a tie against requester 3.
- **Withdrawn request:** requester 1 asserts s_arvalid while requester 0 is being served, then drops it before grant. Requester 1 is never granted and no transaction appears for it on m_ar*.
